// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors, transmit FSM states and baud-divisor helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE  = 0;
  localparam int unsigned PARITY_EVEN  = 1;
  localparam int unsigned PARITY_ODD   = 2;
  localparam int unsigned PARITY_MARK0 = 3;
  localparam int unsigned PARITY_MARK1 = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_t;

  // Clock cycles per serial bit; truncating division
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: free-runs 0..CLKS_PER_BIT-1 while enabled, clear forces 0,
// bit_end is high during the final cycle of each bit period. Shared by TX and RX.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // bit_end registered from the next count so it coincides with cnt == LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      bit_end <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK line condition.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY_TYPE = 1,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned CPB        = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW         = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BW         = $clog2(DATA_WIDTH) + 1;
  localparam bit          HAS_PAR    = (PARITY_TYPE != PARITY_NONE);
  localparam int unsigned FRAME_BITS = 1 + DATA_WIDTH + (HAS_PAR ? 1 : 0) + STOP_BITS;

  if (PARITY_TYPE > PARITY_MARK1) begin : g_bad_parity
    $error("uart_tx_ctrl: PARITY_TYPE %0d is not in 0..4", PARITY_TYPE);
  end
  if (CPB < 2) begin : g_bad_baud
    $error("uart_tx_ctrl: CLKS_PER_BIT %0d must be at least 2", CPB);
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_ctrl: DATA_WIDTH %0d is not in 5..9", DATA_WIDTH);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_ctrl: STOP_BITS %0d is not 1 or 2", STOP_BITS);
  end

  tx_state_t             state, state_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic                  par_bit, par_next;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic                  tx_next;
  logic                  done_next;
  logic                  last_stop;
  logic [CW-1:0]         baud_cnt;
  logic                  bit_end;
`ifdef UART_TX_BREAK_EN
  logic                  in_break, in_break_next;
`endif

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
    case (PARITY_TYPE)
      PARITY_EVEN:  return ^d;
      PARITY_ODD:   return ~^d;
      PARITY_MARK1: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  uart_baud_cnt #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CW)
  ) u_baud (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .cnt    (baud_cnt),
    .bit_end(bit_end)
  );

  assign tx_ready  = (state == IDLE) && !sys_rst;
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

  // Next state plus next line level; tx is registered from tx_next
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    par_next     = par_bit;
    bit_cnt_next = bit_cnt;
    tx_next      = 1'b1;
    done_next    = 1'b0;
`ifdef UART_TX_BREAK_EN
    in_break_next = in_break;
`endif
    case (state)
      IDLE: begin
        bit_cnt_next = '0;
`ifdef UART_TX_BREAK_EN
        in_break_next = 1'b0;
        if (break_req) begin
          state_next    = BREAK;
          in_break_next = 1'b1;
          tx_next       = 1'b0;
        end else
`endif
        if (tx_valid) begin
          state_next = START;
          shreg_next = tx_data;
          par_next   = calc_parity(tx_data);
          tx_next    = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shreg[0];
        end
      end
      DATA: begin
        tx_next = shreg[0];
        if (bit_end) begin
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_next = '0;
            if (HAS_PAR) begin
              state_next = PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
            shreg_next   = {1'b0, shreg[DATA_WIDTH-1:1]};
            tx_next      = shreg[1];
          end
        end
      end
      PARITY: begin
        tx_next = par_bit;
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        tx_next   = 1'b1;
        // Raised one cycle early so the registered pulse lands on the final stop cycle
        done_next = last_stop && (baud_cnt == CW'(CPB - 2));
`ifdef UART_TX_BREAK_EN
        if (in_break) done_next = 1'b0;
`endif
        if (bit_end) begin
          if (last_stop) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        tx_next = 1'b0;
        // Hold low for at least one frame time, then until break_req drops at a bit boundary
        if (bit_end) begin
          if (bit_cnt == BW'(FRAME_BITS - 1)) begin
            if (!break_req) begin
              state_next   = STOP;
              bit_cnt_next = '0;
              tx_next      = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      shreg   <= '0;
      par_bit <= 1'b0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      par_bit <= par_next;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
      tx_busy <= (state_next != IDLE);
      tx_done <= done_next;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_break <= 1'b0;
    end else begin
      in_break <= in_break_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: five parity/stop configurations at 16 clocks per bit,
// frames compared cycle by cycle against a bit-list model built from the frame rules.
module tb_uart_tx_ctrl;

  localparam int NI  = 5;
  localparam int CPB = 16;

  function automatic int unsigned pt_of(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned sb_of(input int i);
    return (i == 4) ? 2 : 1;
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    data [NI];
  logic [NI-1:0] valid;
  logic [NI-1:0] ready;
  logic [NI-1:0] txl;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;
`ifdef UART_TX_BREAK_EN
  logic [NI-1:0] brk;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_ctrl #(
      .CLK_FREQ   (1600),
      .BAUD_RATE  (100),
      .DATA_WIDTH (8),
      .PARITY_TYPE(pt_of(g)),
      .STOP_BITS  (sb_of(g))
    ) u_dut (
      .sys_clk  (clk),
      .sys_rst  (rst),
      .tx_data  (data[g]),
      .tx_valid (valid[g]),
`ifdef UART_TX_BREAK_EN
      .break_req(brk[g]),
`endif
      .tx_ready (ready[g]),
      .tx       (txl[g]),
      .tx_busy  (busy[g]),
      .tx_done  (done[g])
    );
  end

  // Reference frame as a list of line levels, one entry per bit period
  function automatic void build_frame(input int i, input logic [7:0] d,
                                      output logic [15:0] bits, output int n);
    int ones;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int k = 0; k < 8; k++) begin
      bits[n] = d[k]; n++;
    end
    ones = $countones(d);
    case (pt_of(i))
      1: begin bits[n] = logic'(ones % 2);       n++; end
      2: begin bits[n] = logic'(1 - (ones % 2)); n++; end
      3: begin bits[n] = 1'b0;                   n++; end
      4: begin bits[n] = 1'b1;                   n++; end
      default: ;
    endcase
    for (int s = 0; s < int'(sb_of(i)); s++) begin
      bits[n] = 1'b1; n++;
    end
  endfunction

  // Offer d to instance i, then check every cycle of the frame and the idle cycle after it.
  // keep=1 leaves tx_valid high with nd on the bus for a back-to-back follow-on.
  task automatic run_frame(input int i, input logic [7:0] d, input bit keep,
                           input logic [7:0] nd, input string tag);
    logic [15:0] eb, ob;
    int n, len, bad_tx, bad_rdy, done_cnt, done_at, busy_cnt, bi;
    build_frame(i, d, eb, n);
    len = n * CPB;
    data[i]  = d;
    valid[i] = 1'b1;
    checks++;
    if (ready[i] !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept inst=%0d got=%b exp=1", tag, i, ready[i]);
    end
    @(posedge clk);
    @(negedge clk);
    if (keep) data[i] = nd;
    else      valid[i] = 1'b0;
    ob = '0; bad_tx = 0; bad_rdy = 0; done_cnt = 0; done_at = -1; busy_cnt = 0;
    for (int c = 1; c <= len; c++) begin
      bi = (c - 1) / CPB;
      if (txl[i] !== eb[bi]) bad_tx++;
      if ((c - 1) % CPB == CPB / 2) ob[bi] = txl[i];
      if (done[i] === 1'b1) begin done_cnt++; done_at = c; end
      if (busy[i] === 1'b1) busy_cnt++;
      if (ready[i] !== 1'b0) bad_rdy++;
      if (!keep) data[i] = 8'($urandom);
      @(negedge clk);
    end
    checks++;
    if (ob !== eb) begin
      failures++;
      $display("FAIL %s frame_bits inst=%0d data=%h got=%h exp=%h", tag, i, d, ob, eb);
    end
    checks++;
    if (bad_tx != 0) begin
      failures++;
      $display("FAIL %s tx_cycles inst=%0d wrong_cycles=%0d exp=0", tag, i, bad_tx);
    end
    checks++;
    if (done_cnt != 1 || done_at != len) begin
      failures++;
      $display("FAIL %s tx_done inst=%0d pulses=%0d at=%0d exp=1 at %0d", tag, i, done_cnt, done_at, len);
    end
    checks++;
    if (busy_cnt != len || bad_rdy != 0) begin
      failures++;
      $display("FAIL %s busy_ready inst=%0d busy_cycles=%0d ready_wrong=%0d exp=%0d/0", tag, i, busy_cnt, bad_rdy, len);
    end
    checks++;
    if ({txl[i], ready[i], busy[i], done[i]} !== 4'b1100) begin
      failures++;
      $display("FAIL %s idle_gap inst=%0d got tx,ready,busy,done=%b exp=1100", tag, i,
               {txl[i], ready[i], busy[i], done[i]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = '0;
`ifdef UART_TX_BREAK_EN
    brk = '0;
`endif
    for (int i = 0; i < NI; i++) data[i] = 8'h00;
    repeat (3) @(negedge clk);
    valid = '1;
    #1;
    checks++;
    if ({txl, ready, busy, done} !== {{NI{1'b1}}, {NI{1'b0}}, {NI{1'b0}}, {NI{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state got tx=%b ready=%b busy=%b done=%b exp=11111/00000/00000/00000",
               txl, ready, busy, done);
    end
    @(negedge clk);
    valid = '0;
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== {NI{1'b1}} || txl !== {NI{1'b1}}) begin
      failures++;
      $display("FAIL reset_release got ready=%b tx=%b exp=11111/11111", ready, txl);
    end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    run_frame(0, 8'hA5, 1'b0, 8'h00, "8E1_A5");
    run_frame(1, 8'h07, 1'b0, 8'h00, "8O1_07");
    run_frame(0, 8'h07, 1'b0, 8'h00, "8E1_07");
    run_frame(2, 8'hFF, 1'b0, 8'h00, "mark0_FF");
    run_frame(3, 8'hFF, 1'b0, 8'h00, "mark1_FF");
    run_frame(4, 8'h3C, 1'b0, 8'h00, "8N2_3C");
  endtask

  task automatic test_random();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 3; k++) begin
        run_frame(i, 8'($urandom), 1'b0, 8'h00, "random");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    for (int k = 0; k < 3; k++) w[k] = 8'($urandom);
    run_frame(0, w[0], 1'b1, w[1], "b2b_0");
    run_frame(0, w[1], 1'b1, w[2], "b2b_1");
    run_frame(0, w[2], 1'b0, 8'h00, "b2b_2");
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    data[0]  = 8'($urandom);
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    bad = 0;
    for (int c = 1; c < 70; c++) begin
      if (done[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({txl[0], ready[0], busy[0], done[0]} !== 4'b1000) begin
      failures++;
      $display("FAIL mid_reset_async got tx,ready,busy,done=%b exp=1000", {txl[0], ready[0], busy[0], done[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (txl[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_reset_abort wrong_cycles=%0d exp=0", bad);
    end
    run_frame(0, 8'($urandom), 1'b0, 8'h00, "after_reset");
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int low, high, dn, k;
    low = 0; high = 0; dn = 0; k = 0;
    brk[0] = 1'b1;
    while (k < 600) begin
      @(negedge clk);
      k++;
      if (k == 20) brk[0] = 1'b0;
      if (ready[0] === 1'b1) break;
      if (txl[0] === 1'b0) low++;
      else if (txl[0] === 1'b1) high++;
      if (done[0] !== 1'b0) dn++;
    end
    checks++;
    if (k >= 600) begin
      failures++;
      $display("FAIL break_timeout cycles=%0d exp ready within 600", k);
    end
    checks++;
    if (low != 11 * CPB || high != CPB || dn != 0) begin
      failures++;
      $display("FAIL break_timing low=%0d high=%0d done=%0d exp=%0d/%0d/0", low, high, dn, 11 * CPB, CPB);
    end
    run_frame(0, 8'($urandom), 1'b0, 8'h00, "after_break");
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
